mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU (port c) and a DMA/program loader (port d).
- One transaction is in flight at a time.
- Contention is resolved by round-robin arbitration.
- Completion is signalled by a one-cycle ack pulse; the CPU control FSM waits in its memory states until c_ack.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata (legal range 1..15)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
c_req  in  1  CPU request; held high with payload stable until c_ack
c_we  in  1  CPU write (1) / read (0)
c_addr  in  AW  CPU byte address
c_wdata  in  DW  CPU write data
c_ack  out  1  one-cycle pulse: CPU transaction complete; c_rdata valid this cycle for reads
c_rdata  out  DW  CPU read data
d_req  in  1  DMA request (same rules as c_req)
d_we  in  1  DMA write/read
d_addr  in  AW  DMA address
d_wdata  in  DW  DMA write data
d_ack  out  1  DMA completion pulse
d_rdata  out  DW  DMA read data
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable, valid with mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  transaction in flight (state != IDLE)
owner  out  1  0 = CPU, 1 = DMA; requester of the current or last transaction

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - All outputs 0: c_ack, d_ack, c_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
  - owner = 1, so the first tie goes to the CPU.
  - State = IDLE, latency counter = 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant it.
  - Both high: grant the port that is not owner (round-robin).
  - On grant, register the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata, set owner, and go to ACCESS.
- ACCESS:
  - mem_en = 1 for exactly this cycle.
  - Load the latency counter with MEM_LAT-1.
  - Next state: WAIT if MEM_LAT>1, else RESP.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to RESP.
- RESP:
  - Pulse the owner's ack for one cycle.
  - On a read, capture mem_rdata into the owner's rdata register in the same cycle; the other port's rdata is unchanged.
  - Writes leave rdata unchanged.
  - Next state: IDLE.
- Latency: req sampled high in IDLE at cycle t → mem_en at t+1 → ack at t+1+MEM_LAT. Writes use the same timing.
- Back-to-back:
  - A req still high in the cycle after RESP is treated as a new request and re-arbitrated in IDLE.
  - Requesters drop req in the ack cycle to avoid a repeat.
  - Minimum spacing between mem_en pulses is MEM_LAT+2 cycles.
- Request changes mid-transaction: changes to req or payload while busy are ignored. A dropped req does not abort the transaction; the memory access and ack still occur.
- Hold rules: mem_addr, mem_we and mem_wdata hold their values outside ACCESS. mem_we is meaningful only with mem_en.
- Reset mid-operation: return to IDLE at the next edge. No ack is issued, no further mem_en, owner returns to 1.
- Exclusivity: c_ack and d_ack are never high in the same cycle. mem_en is never high in two consecutive cycles.

Test Plan:
- MEM_LAT=1, CPU read: c_req=1, c_addr=0x10 at cycle 0; mem_rdata=0xDEADBEEF → mem_en at cycle 1 with mem_addr=0x10, c_ack at cycle 2, c_rdata=0xDEADBEEF, d_ack stays 0.
- Tie after reset: c_req and d_req both high at cycle 0 (c read 0x20, d write 0x40/0x12345678) → CPU served first (c_ack cycle 2). DMA then gets mem_en at cycle 4 with mem_we=1, mem_wdata=0x12345678, and d_ack at cycle 5.
- Sustained contention: both reqs held high, each re-asserted immediately after its ack, 6 transactions → grants alternate C,D,C,D,C,D; owner toggles each transaction.
- MEM_LAT=3, DMA back-to-back reads of 0x0 and 0x4 → mem_en at cycles 1 and 6, d_ack at cycles 4 and 9; d_rdata captured correctly each time.
- Reset mid-operation: reset asserted in the WAIT cycle of a CPU read (MEM_LAT=3) → no c_ack, busy=0 and owner=1 the next cycle; a fresh c_req completes normally.
- Dropped request: c_req deasserted the cycle after grant → the memory access still occurs and c_ack still pulses once; the arbiter then returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one unified instruction/data
// memory between the CPU (port c) and a DMA/program loader (port d).
// One transaction is in flight at a time. The sequence is IDLE, then ACCESS
// (a one-cycle mem_en), then optional WAIT cycles, then RESP (ack pulse).
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata  CPU request and payload (held until c_ack)
//   c_ack, c_rdata          CPU completion pulse and read data
//   d_req/d_we/d_addr/d_wdata  DMA request and payload
//   d_ack, d_rdata          DMA completion pulse and read data
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and command
//   mem_rdata               memory read data, valid MEM_LAT cycles after mem_en
//   busy                    a transaction is in flight
//   owner                   0 = CPU, 1 = DMA; current or last requester
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1   = 4'(MEM_LAT - 1);
  localparam bit         HAS_WAIT = (MEM_LAT > 1);

  state_t        state_r, state_s;
  logic [3:0]    cnt_r, cnt_s;
  logic          owner_r, owner_s;
  logic          grant_s;
  logic          win_we_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_wdata_s;

  logic          c_ack_r, d_ack_r, mem_en_r, busy_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic [DW-1:0] c_rdata_r, d_rdata_r;

  // Next-state, round-robin grant and latency counter control.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    owner_s = owner_r;
    grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (c_req || d_req) begin
          grant_s = 1'b1;
          // On a tie the port that did not own the last transaction wins.
          if (c_req && d_req) begin
            owner_s = ~owner_r;
          end else begin
            owner_s = d_req;
          end
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        cnt_s = LAT_M1;
        if (HAS_WAIT) begin
          state_s = WAIT;
        end else begin
          state_s = RESP;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Payload of the port being granted this cycle.
  always_comb begin
    win_we_s    = c_we;
    win_addr_s  = c_addr;
    win_wdata_s = c_wdata;
    if (owner_s) begin
      win_we_s    = d_we;
      win_addr_s  = d_addr;
      win_wdata_s = d_wdata;
    end else begin
      win_we_s    = c_we;
      win_addr_s  = c_addr;
      win_wdata_s = c_wdata;
    end
  end

  // State, command and response registers; outputs are decoded from the
  // next state so they are glitch-free registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      owner_r     <= 1'b1;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      busy_r      <= 1'b0;
      c_ack_r     <= 1'b0;
      d_ack_r     <= 1'b0;
      c_rdata_r   <= '0;
      d_rdata_r   <= '0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      owner_r  <= owner_s;
      mem_en_r <= (state_s == ACCESS);
      busy_r   <= (state_s != IDLE);
      c_ack_r  <= (state_s == RESP) && !owner_s;
      d_ack_r  <= (state_s == RESP) && owner_s;
      if (grant_s) begin
        mem_we_r    <= win_we_s;
        mem_addr_r  <= win_addr_s;
        mem_wdata_r <= win_wdata_s;
      end else begin
        mem_we_r    <= mem_we_r;
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
      // Read data arrives in the ack cycle; keep it for later cycles.
      if (c_ack_r && !mem_we_r) begin
        c_rdata_r <= mem_rdata;
      end else begin
        c_rdata_r <= c_rdata_r;
      end
      if (d_ack_r && !mem_we_r) begin
        d_rdata_r <= mem_rdata;
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

  // mem_rdata is only valid during the ack cycle, so it is forwarded then
  // and the captured copy is shown afterwards.
  assign c_rdata   = (c_ack_r && !mem_we_r) ? mem_rdata : c_rdata_r;
  assign d_rdata   = (d_ack_r && !mem_we_r) ? mem_rdata : d_rdata_r;
  assign c_ack     = c_ack_r;
  assign d_ack     = d_ack_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign owner     = owner_r;

endmodule
